// File: rtl/interrupt_arbiter_if.sv
// Signal bundle between the interrupt arbiter, the interrupt sources and the CPU interrupt unit.
// The arbiter connects through the slave modport and its environment through the master modport.
interface interrupt_arbiter_if #(
  parameter int NUM_SRC = 8
);
  logic [NUM_SRC-1:0] irq_req;
  logic               mask_we;
  logic [15:0]        mask_wdata;
  logic               int_ack;
  logic               eret_n;
  logic               int_signal_n;
  logic [3:0]         int_index;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic               busy;

  modport master (
    output irq_req, mask_we, mask_wdata, int_ack, eret_n,
    input  int_signal_n, int_index, pending, mask, busy
  );

  modport slave (
    input  irq_req, mask_we, mask_wdata, int_ack, eret_n,
    output int_signal_n, int_index, pending, mask, busy
  );
endinterface

// File: rtl/interrupt_arbiter.sv
// Non-nesting priority interrupt controller: latches rising edges as pending, masks them,
// and requests the lowest-numbered eligible source until the CPU acknowledges and returns.
module interrupt_arbiter #(
  parameter int NUM_SRC = 8
) (
  input  logic                clk,
  input  logic                rst,
  interrupt_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [3:0]         int_index_q, int_index_d;
  logic               int_signal_n_q, int_signal_n_d;
  logic               busy_q, busy_d;

  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] ack_clr_s;
  logic [3:0]         winner_s;
  logic               unused_wdata_s;

  // Upper mask bits beyond the implemented sources are deliberately discarded.
  assign unused_wdata_s = ^bus.mask_wdata;

  // Next-state, pending/mask update and registered-output precomputation.
  always_comb begin
    rise_s     = bus.irq_req & ~irq_prev_q;
    eligible_s = pending_q & ~mask_q;
    ack_clr_s  = NUM_SRC'(1) << int_index_q;

    winner_s = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      winner_s = eligible_s[i] ? 4'(i) : winner_s;
    end

    state_d     = state_q;
    int_index_d = int_index_q;
    irq_prev_d  = bus.irq_req;
    pending_d   = pending_q | rise_s;

    if (bus.mask_we) begin
      mask_d = bus.mask_wdata[NUM_SRC-1:0];
    end else begin
      mask_d = mask_q;
    end

    case (state_q)
      IDLE: begin
        if (|eligible_s) begin
          state_d     = REQ;
          int_index_d = winner_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A rise arriving in the ack cycle re-sets the bit being cleared.
        if (bus.int_ack) begin
          state_d   = SERVICE;
          pending_d = (pending_q & ~ack_clr_s) | rise_s;
        end else begin
          state_d = REQ;
        end
      end
      SERVICE: begin
        if (!bus.eret_n) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    int_signal_n_d = (state_d != REQ);
    busy_d         = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      irq_prev_q     <= '0;
      pending_q      <= '0;
      mask_q         <= '1;
      int_index_q    <= 4'd0;
      int_signal_n_q <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      irq_prev_q     <= irq_prev_d;
      pending_q      <= pending_d;
      mask_q         <= mask_d;
      int_index_q    <= int_index_d;
      int_signal_n_q <= int_signal_n_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.int_signal_n = int_signal_n_q;
  assign bus.int_index    = int_index_q;
  assign bus.pending      = pending_q;
  assign bus.mask         = mask_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed scenarios plus randomized traffic for interrupt_arbiter, checked every cycle
// against a transaction-level reference model and a set of hand-computed expectations.
module tb_interrupt_arbiter;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  interrupt_arbiter_if #(.NUM_SRC(N)) bif ();

  interrupt_arbiter #(.NUM_SRC(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a controller is either waiting, requesting a chosen source, or serving it.
  typedef enum int {M_WAIT, M_ASKING, M_SERVING} mode_t;
  mode_t  m_mode = M_WAIT;
  bit [N-1:0] m_pend = '0;
  bit [N-1:0] m_mask = '1;
  bit [N-1:0] m_prev = '0;
  int     m_idx  = 0;

  function automatic int lowest_set(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    bit [N-1:0] rise;
    if (rst) begin
      m_mode = M_WAIT;
      m_pend = '0;
      m_mask = '1;
      m_prev = '0;
      m_idx  = 0;
    end else begin
      rise = bif.irq_req & ~m_prev;
      if (m_mode == M_WAIT) begin
        if (lowest_set(m_pend & ~m_mask) >= 0) begin
          m_idx  = lowest_set(m_pend & ~m_mask);
          m_mode = M_ASKING;
        end
      end else if (m_mode == M_ASKING) begin
        if (bif.int_ack) begin
          m_pend[m_idx] = 1'b0;
          m_mode = M_SERVING;
        end
      end else begin
        if (!bif.eret_n) m_mode = M_WAIT;
      end
      m_pend = m_pend | rise;
      m_prev = bif.irq_req;
      if (bif.mask_we) m_mask = bif.mask_wdata[N-1:0];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_int_signal_n", 32'(bif.int_signal_n), (m_mode == M_ASKING) ? 32'd0 : 32'd1);
      check("model_busy", 32'(bif.busy), (m_mode == M_WAIT) ? 32'd0 : 32'd1);
      check("model_int_index", 32'(bif.int_index), 32'(m_idx));
      check("model_pending", 32'(bif.pending), 32'(m_pend));
      check("model_mask", 32'(bif.mask), 32'(m_mask));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic serve();
    bif.int_ack = 1'b1;
    cyc(1);
    bif.int_ack = 1'b0;
    bif.eret_n  = 1'b0;
    cyc(1);
    bif.eret_n  = 1'b1;
  endtask

  initial begin
    bif.irq_req    = '0;
    bif.mask_we    = 1'b0;
    bif.mask_wdata = 16'h0000;
    bif.int_ack    = 1'b0;
    bif.eret_n     = 1'b1;
    rst            = 1'b1;
    cyc(1);
    cmp_en = 1'b1;
    cyc(1);

    // Reset values
    check("rst_int_signal_n", 32'(bif.int_signal_n), 32'd1);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_pending", 32'(bif.pending), 32'h00);
    check("rst_mask", 32'(bif.mask), 32'hFF);
    check("rst_int_index", 32'(bif.int_index), 32'd0);

    // Single source 3, full handshake
    rst = 1'b0;
    bif.mask_we = 1'b1;
    bif.mask_wdata = 16'h0000;
    cyc(1);
    bif.mask_we = 1'b0;
    check("unmask_all", 32'(bif.mask), 32'h00);
    bif.irq_req = 8'h08;
    cyc(1);
    check("src3_pending", 32'(bif.pending), 32'h08);
    check("src3_not_yet", 32'(bif.int_signal_n), 32'd1);
    bif.irq_req = 8'h00;
    cyc(1);
    check("src3_req", 32'(bif.int_signal_n), 32'd0);
    check("src3_index", 32'(bif.int_index), 32'd3);
    bif.int_ack = 1'b1;
    cyc(1);
    bif.int_ack = 1'b0;
    check("src3_ack_pending", 32'(bif.pending), 32'h00);
    check("src3_ack_busy", 32'(bif.busy), 32'd1);
    check("src3_ack_sig", 32'(bif.int_signal_n), 32'd1);
    bif.eret_n = 1'b0;
    cyc(1);
    bif.eret_n = 1'b1;
    check("src3_eret_busy", 32'(bif.busy), 32'd0);

    // Simultaneous 5 and 2: priority, then one idle cycle gap
    bif.irq_req = 8'h24;
    cyc(1);
    bif.irq_req = 8'h00;
    cyc(1);
    check("prio_first", 32'(bif.int_index), 32'd2);
    check("prio_first_sig", 32'(bif.int_signal_n), 32'd0);
    serve();
    check("gap_idle", 32'(bif.int_signal_n), 32'd1);
    cyc(1);
    check("prio_second", 32'(bif.int_index), 32'd5);
    check("prio_second_sig", 32'(bif.int_signal_n), 32'd0);
    serve();

    // Masked source latches but is not requested until unmasked
    bif.mask_we = 1'b1;
    bif.mask_wdata = 16'h0004;
    cyc(1);
    bif.mask_we = 1'b0;
    bif.irq_req = 8'h04;
    cyc(1);
    bif.irq_req = 8'h00;
    check("masked_pending", 32'(bif.pending), 32'h04);
    cyc(2);
    check("masked_no_req", 32'(bif.int_signal_n), 32'd1);
    bif.mask_we = 1'b1;
    bif.mask_wdata = 16'h0000;
    cyc(1);
    bif.mask_we = 1'b0;
    check("unmask_not_yet", 32'(bif.int_signal_n), 32'd1);
    cyc(1);
    check("unmask_req", 32'(bif.int_signal_n), 32'd0);
    check("unmask_index", 32'(bif.int_index), 32'd2);
    serve();

    // Committed request survives higher-priority arrival and mask write
    bif.irq_req = 8'h10;
    cyc(1);
    bif.irq_req = 8'h00;
    cyc(1);
    check("commit_req", 32'(bif.int_index), 32'd4);
    bif.irq_req = 8'h02;
    bif.mask_we = 1'b1;
    bif.mask_wdata = 16'h0010;
    cyc(1);
    bif.irq_req = 8'h00;
    bif.mask_we = 1'b0;
    check("commit_hold_idx", 32'(bif.int_index), 32'd4);
    check("commit_hold_sig", 32'(bif.int_signal_n), 32'd0);
    cyc(2);
    check("commit_hold_idx2", 32'(bif.int_index), 32'd4);
    bif.int_ack = 1'b1;
    cyc(1);
    bif.int_ack = 1'b0;
    check("commit_svc_idx", 32'(bif.int_index), 32'd4);
    bif.eret_n = 1'b0;
    cyc(1);
    bif.eret_n = 1'b1;
    cyc(1);
    check("commit_next_idx", 32'(bif.int_index), 32'd1);
    check("commit_next_sig", 32'(bif.int_signal_n), 32'd0);
    serve();
    bif.mask_we = 1'b1;
    bif.mask_wdata = 16'h0000;
    cyc(1);
    bif.mask_we = 1'b0;

    // Level-held line requests once; rise in the ack cycle keeps pending set
    bif.irq_req = 8'h01;
    cyc(2);
    check("level_req", 32'(bif.int_signal_n), 32'd0);
    check("level_idx", 32'(bif.int_index), 32'd0);
    serve();
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      check("level_once", 32'(bif.int_signal_n), 32'd1);
    end
    bif.irq_req = 8'h00;
    cyc(1);
    bif.irq_req = 8'h01;
    cyc(1);
    bif.irq_req = 8'h00;
    cyc(1);
    check("reraise_req", 32'(bif.int_signal_n), 32'd0);
    bif.int_ack = 1'b1;
    bif.irq_req = 8'h01;
    cyc(1);
    bif.int_ack = 1'b0;
    check("set_wins", 32'(bif.pending[0]), 32'd1);
    check("set_wins_busy", 32'(bif.busy), 32'd1);
    bif.eret_n = 1'b0;
    cyc(1);
    bif.eret_n = 1'b1;
    cyc(1);
    check("set_wins_rereq", 32'(bif.int_signal_n), 32'd0);
    bif.irq_req = 8'h00;
    serve();

    // Reset during service aborts; stray eret in idle is harmless
    bif.irq_req = 8'h40;
    cyc(1);
    bif.irq_req = 8'h00;
    cyc(1);
    bif.int_ack = 1'b1;
    cyc(1);
    bif.int_ack = 1'b0;
    check("pre_rst_busy", 32'(bif.busy), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("abort_busy", 32'(bif.busy), 32'd0);
    check("abort_sig", 32'(bif.int_signal_n), 32'd1);
    check("abort_pending", 32'(bif.pending), 32'h00);
    check("abort_mask", 32'(bif.mask), 32'hFF);
    bif.eret_n = 1'b0;
    cyc(1);
    bif.eret_n = 1'b1;
    check("stray_eret_busy", 32'(bif.busy), 32'd0);
    check("stray_eret_sig", 32'(bif.int_signal_n), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bif.irq_req    = bif.irq_req ^ N'($urandom & $urandom & $urandom);
      bif.mask_we    = ($urandom_range(0, 19) == 0);
      bif.mask_wdata = 16'($urandom & $urandom);
      bif.int_ack    = ($urandom_range(0, 3) == 0);
      bif.eret_n     = !($urandom_range(0, 4) == 0);
      rst            = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    rst = 1'b0;
    bif.int_ack = 1'b0;
    bif.eret_n = 1'b1;
    bif.mask_we = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Priority interrupt controller that sits in front of the CPU interrupt unit. It collects up to 16 device interrupt lines (timer, UART, keyboard, …), latches rising edges as pending, applies a software-writable mask, and selects the lowest-numbered unmasked pending source. It then drives the active-low interrupt request and 4-bit vector index into the interrupt unit. Nesting is not supported: after a request is accepted, the arbiter issues nothing further until the CPU returns with `eret_n`.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, legal range 1..16.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `irq_req`  in  NUM_SRC  device request lines, active-high; rising edge detected.
- `mask_we`  in  1  mask write strobe, one cycle.
- `mask_wdata`  in  16  new mask; bit i = 1 masks source i; bits ≥ NUM_SRC ignored.
- `int_ack`  in  1  CPU interrupt unit accepted the current request.
- `eret_n`  in  1  return-from-interrupt, active-low, one-cycle pulse.
- `int_signal_n`  out  1  interrupt request to CPU, active-low.
- `int_index`  out  4  vector index of requested/in-service source, zero-extended.
- `pending`  out  NUM_SRC  pending register (status readback).
- `mask`  out  NUM_SRC  mask register (status readback).
- `busy`  out  1  high in REQ and SERVICE states.

## Operation
- Edge detect: `irq_prev` registers `irq_req` each cycle. Rise i = `irq_req[i] & ~irq_prev[i]`. A rise sets `pending[i]`. Level-held lines set pending once only.
- Mask: when `mask_we` is high, `mask <= mask_wdata[NUM_SRC-1:0]` (takes effect next cycle). Masked sources still latch pending; they are excluded from arbitration only.
- Eligible = `pending & ~mask`. Winner = lowest set bit index.
- FSM, 3 states:
  - IDLE: `int_signal_n=1`, `busy=0`. If eligible ≠ 0, latch winner into `int_index` and go to REQ.
  - REQ: `int_signal_n=0`, `busy=1`; `int_index` is held stable. On `int_ack`, clear `pending[int_index]` and go to SERVICE. The request is committed: later mask writes or higher-priority arrivals do not withdraw or change it.
  - SERVICE: `int_signal_n=1`, `busy=1`; `int_index` holds the in-service source. On `eret_n=0`, go to IDLE.
- `eret_n` is ignored in IDLE and REQ. `int_ack` is ignored in IDLE and SERVICE.
- Simultaneous set and clear of the same pending bit (new rise in the ack cycle): set wins and the bit stays pending.
- New edges continue to latch during REQ and SERVICE. They are arbitrated after return.

## Timing
- Reset values: `int_signal_n=1`, `int_index=0`, `busy=0`, `pending=0`, `irq_prev=0`, `mask` all ones (all masked), FSM=IDLE.
- Reset during REQ/SERVICE aborts immediately. All outputs take reset values after that edge; no residual request.
- Latency, rise to request: line rises before edge k → `pending[i]=1` after k → `int_signal_n=0`, `int_index` valid after k+1.
- Ack: `int_ack` sampled at edge m in REQ → `int_signal_n=1` and pending bit cleared after m.
- Return: `eret_n=0` at edge r in SERVICE → IDLE after r. If eligible ≠ 0, the next request asserts after r+1. Minimum gap between requests is one IDLE cycle.
- Mask write at edge w affects arbitration from edge w+1 onward.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset, then `mask_wdata=0x0000`; pulse `irq_req[3]` → `pending=0x08`. Two edges after the rise, `int_signal_n=0` and `int_index=3`. `int_ack` → `pending=0`, `busy=1`. `eret_n` pulse → `busy=0`.
- Simultaneous rises on sources 5 and 2 → `int_index=2` first. After ack and eret, `int_index=5` is requested one IDLE cycle later.
- Mask `0x0004`, rise on source 2 → `pending=0x04`, no request. Write mask `0x0000` → request with `int_index=2` two edges after the write.
- In REQ for source 4, rise on source 1 and write mask `0x0010` → `int_index` stays 4 until ack. After eret, source 1 is served.
- Hold `irq_req[0]` high for 20 cycles → exactly one request. A new rise on the same line in the ack cycle leaves `pending[0]=1`.
- Assert `rst` while in SERVICE → next cycle `busy=0`, `int_signal_n=1`, `pending=0`, `mask` all ones. A stray `eret_n` pulse in IDLE has no effect.
